// File: rtl/scaler_scheduler_if.sv
// ---------------------------------------------------------------------------
// scaler_scheduler_if
// Command handshake between a command source and the scaler scheduler.
//   cmd_valid  : source has a command
//   cmd_ready  : scheduler can accept a command (only while idle)
//   cmd_mode   : engine index to run
//   cmd_width  : source image width
//   cmd_height : source image height
// master = command source, slave = scheduler.
// ---------------------------------------------------------------------------
interface scaler_scheduler_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_mode;
  logic [15:0] cmd_width;
  logic [15:0] cmd_height;

  modport master (
    output cmd_valid, cmd_mode, cmd_width, cmd_height,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_width, cmd_height,
    output cmd_ready
  );
endinterface

// File: rtl/scaler_scheduler.sv
// ---------------------------------------------------------------------------
// scaler_scheduler
// Runs one of N_ENG scaling engines at a time on a shared ROM/RAM port pair.
// A command selects the engine and the image size; the scheduler holds every
// other engine in reset, muxes the selected engine onto the memory ports and
// waits for its done flag, guarded by a watchdog.
//
// Optional feature: define SCALER_CLEAR_FB_EN to zero the FB_WORDS-word
// framebuffer (one word per cycle) before the engine is released.
//
// Ports
//   clock, reset         : sole clock, synchronous active-high reset
//   cmd_if (slave)       : command handshake (valid/ready, mode, width, height)
//   cfg_width/cfg_height : latched dimensions, broadcast to the engines
//   eng_reset            : per-engine reset, 0 only for the running engine
//   eng_*                : packed per-engine memory requests and done flags
//   rom_addr, ram_*      : shared memory ports
//   busy, done, error    : status; done/error are one-cycle pulses
//
// States
//   IDLE  | waiting for a command, cmd_ready high
//   CLEAR | zeroing the framebuffer (SCALER_CLEAR_FB_EN only)
//   ARM   | one cycle with every engine still in reset
//   RUN   | selected engine out of reset and owns the memory ports
//   FIN   | done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module scaler_scheduler #(
  parameter int N_ENG     = 4,
  parameter int WDOG_BITS = 24,
  parameter int FB_WORDS  = 307200
) (
  input  logic                 clock,
  input  logic                 reset,
  scaler_scheduler_if.slave    cmd_if,
  output logic [15:0]          cfg_width,
  output logic [15:0]          cfg_height,
  output logic [N_ENG-1:0]     eng_reset,
  input  logic [17*N_ENG-1:0]  eng_rom_addr,
  input  logic [19*N_ENG-1:0]  eng_ram_addr,
  input  logic [8*N_ENG-1:0]   eng_ram_data,
  input  logic [N_ENG-1:0]     eng_ram_wren,
  input  logic [N_ENG-1:0]     eng_done,
  output logic [16:0]          rom_addr,
  output logic [18:0]          ram_addr,
  output logic [7:0]           ram_data,
  output logic                 ram_wren,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef SCALER_CLEAR_FB_EN
    S_CLEAR,
`endif
    S_ARM,
    S_RUN,
    S_FIN
  } state_e;

  // ram_addr is 19 bits wide, so one clear pass can cover at most 2**19 words.
  if (FB_WORDS < 1 || FB_WORDS > 524288) begin : g_fb_words_out_of_range
  end

  state_e                state_q, state_d;
  logic [2:0]            mode_q, mode_d;
  logic [15:0]           width_q, width_d;
  logic [15:0]           height_q, height_d;
  logic                  error_q, error_d;
  logic [WDOG_BITS-1:0]  wdog_q, wdog_d;
`ifdef SCALER_CLEAR_FB_EN
  logic [18:0]           clr_q, clr_d;
`endif

  logic                  cmd_ok;
  logic [N_ENG-1:0]      sel_onehot;
  logic [16:0]           sel_rom;
  logic [18:0]           sel_ram_addr;
  logic [7:0]            sel_ram_data;
  logic                  sel_wren;
  logic                  sel_done;

  // Slice of the engine named by the latched mode; only meaningful in RUN,
  // where mode_q is guaranteed to be a legal engine index.
  always_comb begin
    sel_onehot   = '0;
    sel_rom      = '0;
    sel_ram_addr = '0;
    sel_ram_data = '0;
    sel_wren     = 1'b0;
    sel_done     = 1'b0;
    for (int k = 0; k < N_ENG; k++) begin
      if (mode_q == 3'(k)) begin
        sel_onehot[k] = 1'b1;
        sel_rom       = eng_rom_addr[17*k +: 17];
        sel_ram_addr  = eng_ram_addr[19*k +: 19];
        sel_ram_data  = eng_ram_data[8*k +: 8];
        sel_wren      = eng_ram_wren[k];
        sel_done      = eng_done[k];
      end
    end
  end

  assign cmd_ok = (int'(cmd_if.cmd_mode) < N_ENG) &&
                  (cmd_if.cmd_width != 16'd0) && (cmd_if.cmd_height != 16'd0);

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    width_d  = width_q;
    height_d = height_q;
    error_d  = 1'b0;
    wdog_d   = wdog_q;
`ifdef SCALER_CLEAR_FB_EN
    clr_d    = clr_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (cmd_if.cmd_valid) begin
          mode_d   = cmd_if.cmd_mode;
          width_d  = cmd_if.cmd_width;
          height_d = cmd_if.cmd_height;
          if (cmd_ok) begin
`ifdef SCALER_CLEAR_FB_EN
            state_d = S_CLEAR;
            clr_d   = '0;
`else
            state_d = S_ARM;
`endif
          end else begin
            error_d = 1'b1;
          end
        end
      end
`ifdef SCALER_CLEAR_FB_EN
      S_CLEAR: begin
        if (clr_q == 19'(FB_WORDS - 1)) state_d = S_ARM;
        else                            clr_d   = clr_q + 19'd1;
      end
`endif
      S_ARM: begin
        wdog_d  = '0;
        state_d = S_RUN;
      end
      S_RUN: begin
        wdog_d = wdog_q + WDOG_BITS'(1);
        // The engine finishing wins over a watchdog expiry in the same cycle.
        if (sel_done) begin
          state_d = S_FIN;
        end else if (wdog_d == '1) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      mode_q   <= '0;
      width_q  <= '0;
      height_q <= '0;
      error_q  <= 1'b0;
      wdog_q   <= '0;
`ifdef SCALER_CLEAR_FB_EN
      clr_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      width_q  <= width_d;
      height_q <= height_d;
      error_q  <= error_d;
      wdog_q   <= wdog_d;
`ifdef SCALER_CLEAR_FB_EN
      clr_q    <= clr_d;
`endif
    end
  end

  always_comb begin
    cmd_if.cmd_ready = (state_q == S_IDLE);
    busy       = (state_q != S_IDLE);
    done       = (state_q == S_FIN);
    error      = error_q;
    cfg_width  = width_q;
    cfg_height = height_q;
    eng_reset  = '1;
    rom_addr   = '0;
    ram_addr   = '0;
    ram_data   = '0;
    ram_wren   = 1'b0;
    if (state_q == S_RUN) begin
      eng_reset = ~sel_onehot;
      rom_addr  = sel_rom;
      ram_addr  = sel_ram_addr;
      ram_data  = sel_ram_data;
      ram_wren  = sel_wren;
    end
`ifdef SCALER_CLEAR_FB_EN
    if (state_q == S_CLEAR) begin
      ram_addr = clr_q;
      ram_wren = 1'b1;
    end
`endif
  end

endmodule

// File: tb/tb_scaler_scheduler.sv
module tb_scaler_scheduler;
  localparam int N  = 4;
  localparam int WB = 8;
  localparam int FB = 16;
  // Last RUN cycle index the watchdog allows (counter would reach all-ones).
  localparam int WD_LAST = (1 << WB) - 2;
`ifdef SCALER_CLEAR_FB_EN
  localparam int CLR = FB;
`else
  localparam int CLR = 0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  scaler_scheduler_if cmd_if ();

  logic [15:0]     cfg_width, cfg_height;
  logic [N-1:0]    eng_reset;
  logic [17*N-1:0] eng_rom_addr = '0;
  logic [19*N-1:0] eng_ram_addr = '0;
  logic [8*N-1:0]  eng_ram_data = '0;
  logic [N-1:0]    eng_ram_wren = '0;
  logic [N-1:0]    eng_done = '0;
  logic [16:0]     rom_addr;
  logic [18:0]     ram_addr;
  logic [7:0]      ram_data;
  logic            ram_wren, busy, done, error;

  scaler_scheduler #(.N_ENG(N), .WDOG_BITS(WB), .FB_WORDS(FB)) dut (
    .clock        (clock),
    .reset        (reset),
    .cmd_if       (cmd_if.slave),
    .cfg_width    (cfg_width),
    .cfg_height   (cfg_height),
    .eng_reset    (eng_reset),
    .eng_rom_addr (eng_rom_addr),
    .eng_ram_addr (eng_ram_addr),
    .eng_ram_data (eng_ram_data),
    .eng_ram_wren (eng_ram_wren),
    .eng_done     (eng_done),
    .rom_addr     (rom_addr),
    .ram_addr     (ram_addr),
    .ram_data     (ram_data),
    .ram_wren     (ram_wren),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model: a timeline of cycle numbers derived when a command is
  // accepted (clear window, run window, done/error cycle, idle-again cycle).
  int idle_from, err_cyc, done_cyc;
  int clr_first, clr_last, run_first, run_last;
  int m_sel, m_delay;
  logic [15:0] m_w, m_h;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    idle_from = cyc; err_cyc = -1; done_cyc = -1;
    clr_first = -10; clr_last = -11; run_first = -10; run_last = -11;
    m_sel = 0; m_delay = 0; m_w = '0; m_h = '0;
  endtask

  // One clock cycle: drive inputs, compare all outputs, advance model+clock.
  // d is the RUN cycle index at which the engine raises done if accepted.
  task automatic step(input logic v, input logic [2:0] md, input logic [15:0] w,
                      input logic [15:0] h, input int d, input logic rst);
    logic in_run, in_clr;
    logic [N-1:0] exp_rst;
    in_run = (cyc >= run_first) && (cyc <= run_last);
    in_clr = (cyc >= clr_first) && (cyc <= clr_last);
    eng_rom_addr = (17*N)'({$urandom, $urandom, $urandom});
    eng_ram_addr = (19*N)'({$urandom, $urandom, $urandom});
    eng_ram_data = $urandom;
    eng_ram_wren = N'($urandom);
    eng_done     = N'($urandom);
    if (in_run) eng_done[m_sel] = (cyc == run_first + m_delay);
    cmd_if.cmd_valid  = v;
    cmd_if.cmd_mode   = md;
    cmd_if.cmd_width  = w;
    cmd_if.cmd_height = h;
    reset = rst;
    #2;
    exp_rst = in_run ? ~(N'(1) << m_sel) : '1;
    chk("cmd_ready", 64'(cmd_if.cmd_ready), 64'(cyc >= idle_from));
    chk("busy", 64'(busy), 64'(cyc < idle_from));
    chk("done", 64'(done), 64'(cyc == done_cyc));
    chk("error", 64'(error), 64'(cyc == err_cyc));
    chk("cfg_width", 64'(cfg_width), 64'(m_w));
    chk("cfg_height", 64'(cfg_height), 64'(m_h));
    chk("eng_reset", 64'(eng_reset), 64'(exp_rst));
    chk("rom_addr", 64'(rom_addr), in_run ? 64'(eng_rom_addr[m_sel*17 +: 17]) : 64'(0));
    chk("ram_wren", 64'(ram_wren), in_run ? 64'(eng_ram_wren[m_sel]) : 64'(in_clr));
    chk("ram_addr", 64'(ram_addr), in_run ? 64'(eng_ram_addr[m_sel*19 +: 19])
                                          : (in_clr ? 64'(cyc - clr_first) : 64'(0)));
    chk("ram_data", 64'(ram_data), in_run ? 64'(eng_ram_data[m_sel*8 +: 8]) : 64'(0));
    if (rst) begin
      if (run_last > cyc) run_last = cyc;
      if (clr_last > cyc) clr_last = cyc;
      if (err_cyc > cyc) err_cyc = -1;
      if (done_cyc > cyc) done_cyc = -1;
      idle_from = cyc + 1;
      m_w = '0; m_h = '0;
    end else if (v && cyc >= idle_from) begin
      m_w = w; m_h = h;
      if (int'(md) >= N || w == 16'd0 || h == 16'd0) begin
        err_cyc = cyc + 1;
        idle_from = cyc + 1;
      end else begin
        m_sel = int'(md); m_delay = d;
        clr_first = cyc + 1; clr_last = cyc + CLR;
        run_first = cyc + CLR + 2;
        run_last  = run_first + ((d <= WD_LAST) ? d : WD_LAST);
        if (d <= WD_LAST) begin
          done_cyc = run_last + 1; idle_from = run_last + 2;
        end else begin
          err_cyc = run_last + 1; idle_from = run_last + 1;
        end
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 16'd0, 16'd0, 0, 1'b0);
  endtask

  task automatic finish_job(input logic noisy);
    while (cyc < idle_from)
      step(noisy ? 1'($urandom) : 1'b0, 3'($urandom), 16'($urandom), 16'($urandom), 5, 1'b0);
  endtask

  typedef struct {
    logic [2:0]  mode;
    logic [15:0] w;
    logic [15:0] h;
    int          delay;
    logic        exp_err;
    logic        exp_busy;
  } vec_t;

  vec_t vt[9];
  int ndone;

  initial begin
    vt[0] = '{3'd0, 16'd4,   16'd4,   64,      1'b0, 1'b1};
    vt[1] = '{3'd5, 16'd4,   16'd4,   0,       1'b1, 1'b0};
    vt[2] = '{3'd1, 16'd0,   16'd8,   3,       1'b1, 1'b0};
    vt[3] = '{3'd2, 16'd8,   16'd0,   3,       1'b1, 1'b0};
    vt[4] = '{3'd3, 16'd640, 16'd480, 10,      1'b0, 1'b1};
    vt[5] = '{3'd4, 16'd4,   16'd4,   2,       1'b1, 1'b0};
    vt[6] = '{3'd7, 16'd1,   16'd1,   2,       1'b1, 1'b0};
    vt[7] = '{3'd1, 16'd1,   16'd1,   0,       1'b0, 1'b1};
    vt[8] = '{3'd2, 16'd2,   16'd2,   WD_LAST, 1'b0, 1'b1};

    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_mode = '0;
    cmd_if.cmd_width = '0;   cmd_if.cmd_height = '0;
    repeat (3) @(posedge clock);
    #1;
    model_reset();
    idle_n(3);

    // Command table: error and busy one cycle after acceptance.
    for (int i = 0; i < 9; i++) begin
      step(1'b1, vt[i].mode, vt[i].w, vt[i].h, vt[i].delay, 1'b0);
      chk("tbl_error", 64'(error), 64'(vt[i].exp_err));
      chk("tbl_busy", 64'(busy), 64'(vt[i].exp_busy));
      chk("tbl_cfg_width", 64'(cfg_width), 64'(vt[i].w));
      finish_job(1'b0);
      idle_n(2);
    end

    // Mode 0, done 64 cycles into RUN: exactly one done pulse.
    ndone = 0;
    step(1'b1, 3'd0, 16'd4, 16'd4, 64, 1'b0);
    while (cyc < idle_from) begin
      step(1'b0, 3'd0, 16'd0, 16'd0, 0, 1'b0);
      if (done) ndone++;
    end
    chk("done_pulse_count", 64'(ndone), 64'(1));

    // Invalid width then a valid command on the very next cycle.
    step(1'b1, 3'd1, 16'd0, 16'd4, 0, 1'b0);
    step(1'b1, 3'd1, 16'd4, 16'd4, 7, 1'b0);
    chk("second_cmd_busy", 64'(busy), 64'(1));
    finish_job(1'b0);

    // Engine never finishes: watchdog error, commands while busy ignored.
    step(1'b1, 3'd3, 16'd4, 16'd4, 100000, 1'b0);
    finish_job(1'b1);
    idle_n(3);

    // Reset in the middle of engine 2's run.
    step(1'b1, 3'd2, 16'd4, 16'd4, 100000, 1'b0);
    idle_n(CLR + 8);
    step(1'b0, 3'd0, 16'd0, 16'd0, 0, 1'b1);
    chk("rst_ram_wren", 64'(ram_wren), 64'(0));
    chk("rst_eng_reset", 64'(eng_reset), 64'(4'b1111));
    chk("rst_cmd_ready", 64'(cmd_if.cmd_ready), 64'(1));
    idle_n(2);

    // Random commands with random traffic and occasional resets.
    for (int j = 0; j < 40; j++) begin
      int gap, dly;
      logic [15:0] rw, rh;
      gap = $urandom_range(0, 3);
      idle_n(gap);
      rw = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 2000));
      rh = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom_range(1, 2000));
      dly = ($urandom_range(0, 5) == 0) ? $urandom_range(250, 260) : $urandom_range(0, 40);
      step(1'b1, 3'($urandom_range(0, 5)), rw, rh, dly, 1'b0);
      while (cyc < idle_from)
        step(1'($urandom), 3'($urandom), 16'($urandom), 16'($urandom), 3,
             ($urandom_range(0, 149) == 0));
    end
    idle_n(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/scaler_scheduler.md
SCALER_SCHEDULER -- requirements
Module: scaler_scheduler

Interface
REQ-001 Parameter: N_ENG, default 4, number of scaling engines sharing the ROM/RAM port pair.
REQ-002 Parameter: WDOG_BITS, default 24, watchdog counter width.
REQ-003 Parameter: FB_WORDS, default 307200, framebuffer size in words (640x480).
REQ-004 clock  input  1  sole clock; one clock; all state changes on rising edge.
REQ-005 reset  input  1  reset is synchronous and active-high.
REQ-006 cmd_valid  input  1  command request.
REQ-007 cmd_ready  output  1  scheduler can accept a command.
REQ-008 cmd_mode  input  3  engine index to run.
REQ-009 cmd_width, cmd_height  input  16 each  source image dimensions.
REQ-010 cfg_width, cfg_height  output  16 each  latched dimensions, broadcast to all engines.
REQ-011 eng_reset  output  N_ENG  per-engine synchronous reset.
REQ-012 eng_rom_addr  input  17*N_ENG  packed engine ROM addresses; engine k occupies bits [17k+16:17k].
REQ-013 eng_ram_addr  input  19*N_ENG, eng_ram_data  input  8*N_ENG, eng_ram_wren  input  N_ENG, eng_done  input  N_ENG; all packed the same way as eng_rom_addr.
REQ-014 rom_addr  output  17; ram_addr  output  19; ram_data  output  8; ram_wren  output  1  shared memory ports.
REQ-015 busy  output  1; done  output  1; error  output  1.

Function
REQ-016 States: IDLE, CLEAR, ARM, RUN, FIN.
REQ-017 cmd_ready SHALL be 1 only in IDLE; a command is accepted when cmd_valid and cmd_ready are both 1 on the same edge (cycle T).
REQ-018 On acceptance, mode, width and height SHALL be latched, and cfg_width/cfg_height SHALL update at T+1.
REQ-019 A command with mode >= N_ENG, width == 0 or height == 0 SHALL pulse error for one cycle at T+1 and leave the block in IDLE.
REQ-020 A valid command SHALL move the block to CLEAR, or to ARM when the clear feature is compiled out.
REQ-021 ARM lasts exactly one cycle; eng_reset of every engine stays 1 during ARM.
REQ-022 In RUN, eng_reset[sel] SHALL be 0 and every other eng_reset bit SHALL be 1; outside RUN all eng_reset bits are 1.
REQ-023 In RUN, rom_addr, ram_addr, ram_data and ram_wren SHALL combinationally pass through the selected engine's slice.
REQ-024 Outside RUN and CLEAR, ram_wren, ram_addr and ram_data SHALL be 0; rom_addr SHALL be 0 outside RUN.
REQ-025 Once eng_done[sel] is 1 in RUN, the block SHALL move to FIN; the same cycle's pass-through write still occurs.
REQ-026 FIN SHALL pulse done for one cycle, then return to IDLE.
REQ-027 eng_done bits of non-selected engines SHALL be ignored.
REQ-028 Watchdog: the counter clears on entry to RUN and increments each RUN cycle.
REQ-029 When the watchdog reaches all-ones, the block SHALL pulse error, skip done and return to IDLE.
REQ-030 eng_done and watchdog saturation in the same cycle SHALL resolve as done; no error pulse.
REQ-031 busy SHALL be 1 in every state except IDLE.
REQ-032 cmd_valid while busy SHALL be ignored and SHALL NOT be queued.

Reset
REQ-033 reset SHALL force IDLE from any state, including mid-CLEAR and mid-RUN.
REQ-034 Reset values: cmd_ready=1 from the first cycle after reset; done=0; error=0; busy=0; ram_wren=0; ram_addr=0; ram_data=0; rom_addr=0; eng_reset all 1; cfg_width=0; cfg_height=0; watchdog=0.

Configuration
REQ-035 Macro SCALER_CLEAR_FB_EN defined: the CLEAR state writes ram_data=0 with ram_wren=1 to ram_addr 0..FB_WORDS-1, one word per cycle, then enters ARM (FB_WORDS cycles).
REQ-036 Macro SCALER_CLEAR_FB_EN undefined: the CLEAR state and its address counter SHALL not exist, and a valid command goes directly to ARM.

Verification
REQ-037 Command mode=0, 4x4, engine 0 asserts eng_done 64 cycles into RUN -> eng_reset[0] falls at T+2 (clear off), done pulses once, busy falls, and the other eng_reset bits stay 1 throughout.
REQ-038 Command mode=5, 4x4 -> error=1 for exactly the T+1 cycle, no ram_wren, block remains IDLE.
REQ-039 Command width=0 -> error pulse at T+1; a second, valid command is accepted immediately afterwards.
REQ-040 Engine never asserts done, WDOG_BITS=8 -> error pulse 255 cycles after RUN entry, then return to IDLE with done never asserted.
REQ-041 reset asserted mid-RUN while engine 2 is writing -> next cycle: ram_wren=0, eng_reset=4'b1111, cmd_ready=1.
REQ-042 With SCALER_CLEAR_FB_EN, FB_WORDS=16 -> 16 consecutive writes of 0 to addresses 0..15, then ARM, then RUN.
